// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared types and constants for the program loader
//
// Purpose: loader FSM state encoding plus the default memory geometry and
// instruction width used by prog_loader and its testbench.
// Ports: none (package).
package rv_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    PAD  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } loader_state_t;

  localparam int MEM_BYTES_DEF = 512;
  localparam int INST_W        = 32;

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream handshake bundle into the loader
//
// Purpose: groups the program byte stream signals.
// Signals:
//   s_valid : a byte is offered on s_data
//   s_data  : program byte
//   s_last  : final byte of the program (meaningful only on a handshake)
//   s_ready : loader accepts a byte this cycle
// Modports: master drives the stream (feeder), slave receives it (loader).
interface prog_loader_if;

  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/prog_loader_byte_ram.sv
// rtl/prog_loader_byte_ram.sv - byte-wide instruction RAM, 1 write / 4 read ports
//
// Purpose: MEM_BYTES x 8 storage. One synchronous write port, four
// combinational read ports so a full 32-bit word can be fetched per cycle.
// Contents have no reset; they survive a loader reset.
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write byte address
//   wdata : write byte
//   raddr : four read byte addresses
//   rdata : four read bytes, rdata[k] = mem[raddr[k]]
module byte_ram #(
  parameter int MEM_BYTES = 512,
  parameter int ADDR_W    = 9
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [7:0]             wdata,
  input  logic [3:0][ADDR_W-1:0] raddr,
  output logic [3:0][7:0]        rdata
);

  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_rd
    assign rdata[k] = mem[raddr[k]];
  end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - loads a byte-streamed program into instruction RAM and serves fetch
//
// Purpose: accepts a program as a byte stream, writes it little-endian into a
// MEM_BYTES instruction memory, pads the tail to a word boundary with zeros,
// holds the core's start high until the program is resident, and serves the
// core's 32-bit instruction fetch combinationally from the same memory.
// MEM_BYTES must be a power of two and a multiple of 4; ADDR_W = log2(MEM_BYTES).
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low; resets control state only
//   s          : byte stream (slave side)
//   pc         : core fetch byte address, only [ADDR_W-1:0] used
//   inst       : {mem[pc+3], mem[pc+2], mem[pc+1], mem[pc]}, addresses wrap
//   start      : core hold, high until load completes
//   load_done  : program resident, core running
//   byte_count : bytes written so far, pad bytes included
//   error      : overflow, sticky until reset
module prog_loader
  import rv_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
  input  logic              clk,
  input  logic              reset,
  prog_loader_if.slave      s,
  input  logic [63:0]       pc,
  output logic [INST_W-1:0] inst,
  output logic              start,
  output logic              load_done,
  output logic [ADDR_W:0]   byte_count,
  output logic              error
);

  localparam logic [ADDR_W:0] PTR_FULL = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

  loader_state_t state, state_n;

  // ptr is one bit wider than the address so a completely full memory
  // (ptr == MEM_BYTES) is distinguishable from an empty one.
  logic [ADDR_W:0] ptr, ptr_n, ptr_inc;
  logic            hs;

  logic                   ram_we;
  logic [ADDR_W-1:0]      ram_waddr;
  logic [7:0]             ram_wdata;
  logic [3:0][ADDR_W-1:0] ram_raddr;
  logic [3:0][7:0]        ram_rdata;

  logic [ADDR_W-1:0] pc_base;
  logic              unused_pc_hi;

  assign ptr_inc = ptr + PTR_ONE;

  // Ready depends on state only, never on s_valid.
  assign s.s_ready = (state == IDLE) || (state == LOAD);
  assign hs        = s.s_valid && s.s_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    ram_we    = 1'b0;
    ram_waddr = ptr[ADDR_W-1:0];
    ram_wdata = s.s_data;

    unique case (state)
      IDLE, LOAD: begin
        if (hs) begin
          if (ptr == PTR_FULL) begin
            // Memory already full: drop the byte and latch the error.
            state_n = ERR;
          end else begin
            ram_we = 1'b1;
            ptr_n  = ptr_inc;
            if (s.s_last) begin
              state_n = (ptr_inc[1:0] != 2'b00) ? PAD : DONE;
            end else begin
              state_n = LOAD;
            end
          end
        end
      end

      PAD: begin
        // Zero-fill up to the next word boundary, one byte per cycle.
        ram_we    = 1'b1;
        ram_wdata = 8'h00;
        ptr_n     = ptr_inc;
        if (ptr_inc[1:0] == 2'b00) begin
          state_n = DONE;
        end
      end

      DONE, ERR: begin
        state_n = state;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign start      = (state != DONE);
  assign load_done  = (state == DONE);
  assign error      = (state == ERR);
  assign byte_count = ptr;

  // Fetch: four consecutive byte addresses, wrapping within the memory.
  assign pc_base      = pc[ADDR_W-1:0];
  assign unused_pc_hi = ^pc[63:ADDR_W];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ram_raddr[k] = pc_base + ADDR_W'(k);
    end
  end

  assign inst = {ram_rdata[3], ram_rdata[2], ram_rdata[1], ram_rdata[0]};

  byte_ram #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking testbench for prog_loader
module tb_prog_loader;
  import rv_pkg::*;

  localparam int MB = 512;

  logic        clk;
  logic        reset;
  logic [63:0] pc;
  logic [31:0] inst;
  logic        start;
  logic        load_done;
  logic        error;
  logic [9:0]  byte_count;

  prog_loader_if bus ();

  prog_loader #(
    .MEM_BYTES (MB),
    .ADDR_W    (9)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s          (bus),
    .pc         (pc),
    .inst       (inst),
    .start      (start),
    .load_done  (load_done),
    .byte_count (byte_count),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         addr;
    logic [7:0] data;
  } sb_t;

  sb_t        sb[$];
  logic [7:0] model_mem [MB];
  int         model_ptr;
  int         pass_cnt;
  int         total_cnt;
  int         start_falls;

  initial start_falls = 0;
  always @(negedge start) start_falls++;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Offer one byte, wait (bounded) for the handshake; returns at a negedge.
  task automatic send_byte(input logic [7:0] d, input logic l, output logic acc);
    acc = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    for (int i = 0; i < 16 && !acc; i++) begin
      if (bus.s_ready) acc = 1'b1;
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    if (acc) begin
      if (model_ptr < MB) begin
        model_mem[model_ptr] = d;
        sb.push_back('{addr: model_ptr, data: d});
        model_ptr++;
      end
    end else begin
      total_cnt++;
      $display("FAIL send_timeout byte=%02h not accepted within 16 cycles", d);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = 8'h00;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_ptr = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (bus.s_ready !== 1'b1) $display("FAIL rst_s_ready got=%b exp=1", bus.s_ready); else pass_cnt++;
    total_cnt++; if (start !== 1'b1) $display("FAIL rst_start got=%b exp=1", start); else pass_cnt++;
    total_cnt++; if (load_done !== 1'b0) $display("FAIL rst_load_done got=%b exp=0", load_done); else pass_cnt++;
    total_cnt++; if (error !== 1'b0) $display("FAIL rst_error got=%b exp=0", error); else pass_cnt++;
    total_cnt++; if (byte_count !== 10'd0) $display("FAIL rst_byte_count got=%0d exp=0", byte_count); else pass_cnt++;
  endtask

  task automatic test_aligned_load();
    logic [7:0] prog [8] = '{8'h83, 8'h00, 8'h01, 8'h00, 8'h03, 8'h82, 8'h01, 8'h00};
    logic acc;
    sb_t  e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        total_cnt++; if (start !== 1'b1) $display("FAIL al_start_before_last got=%b exp=1", start); else pass_cnt++;
      end
      send_byte(prog[i], (i == 7), acc);
    end
    total_cnt++; if (start !== 1'b0) $display("FAIL al_start got=%b exp=0", start); else pass_cnt++;
    total_cnt++; if (load_done !== 1'b1) $display("FAIL al_load_done got=%b exp=1", load_done); else pass_cnt++;
    total_cnt++; if (bus.s_ready !== 1'b0) $display("FAIL al_s_ready got=%b exp=0", bus.s_ready); else pass_cnt++;
    total_cnt++; if (byte_count !== 10'd8) $display("FAIL al_byte_count got=%0d exp=8", byte_count); else pass_cnt++;
    pc = 64'd4; #1;
    total_cnt++; if (inst !== 32'h00018203) $display("FAIL al_inst_pc4 got=%08h exp=00018203", inst); else pass_cnt++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk); pc = 64'(e.addr); #1;
      total_cnt++; if (inst[7:0] !== e.data) $display("FAIL al_sb addr=%0d got=%02h exp=%02h", e.addr, inst[7:0], e.data); else pass_cnt++;
    end
  endtask

  task automatic test_pad();
    logic acc;
    int   pad_cycles;
    sb_t  e;
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(1, 255)), (i == 5), acc);
    total_cnt++; if (byte_count !== 10'd6) $display("FAIL pad_count_after_last got=%0d exp=6", byte_count); else pass_cnt++;
    // Offer a byte during padding; it must be ignored.
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hFF;
    pad_cycles  = 0;
    for (int i = 0; i < 8 && !load_done; i++) begin
      if (bus.s_ready === 1'b0 && start === 1'b1) pad_cycles++;
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    total_cnt++; if (pad_cycles !== 2) $display("FAIL pad_cycles got=%0d exp=2", pad_cycles); else pass_cnt++;
    total_cnt++; if (load_done !== 1'b1) $display("FAIL pad_load_done got=%b exp=1", load_done); else pass_cnt++;
    total_cnt++; if (byte_count !== 10'd8) $display("FAIL pad_byte_count got=%0d exp=8", byte_count); else pass_cnt++;
    model_mem[6] = 8'h00; sb.push_back('{addr: 6, data: 8'h00});
    model_mem[7] = 8'h00; sb.push_back('{addr: 7, data: 8'h00});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk); pc = 64'(e.addr); #1;
      total_cnt++; if (inst[7:0] !== e.data) $display("FAIL pad_sb addr=%0d got=%02h exp=%02h", e.addr, inst[7:0], e.data); else pass_cnt++;
    end
  endtask

  task automatic test_overflow();
    logic acc;
    sb_t  e;
    do_reset();
    for (int i = 0; i < MB; i++) send_byte(8'($urandom), 1'b0, acc);
    total_cnt++; if (byte_count !== 10'd512) $display("FAIL ov_count_full got=%0d exp=512", byte_count); else pass_cnt++;
    total_cnt++; if (error !== 1'b0) $display("FAIL ov_error_early got=%b exp=0", error); else pass_cnt++;
    send_byte(~model_mem[0], 1'b0, acc);
    total_cnt++; if (error !== 1'b1) $display("FAIL ov_error got=%b exp=1", error); else pass_cnt++;
    total_cnt++; if (start !== 1'b1) $display("FAIL ov_start got=%b exp=1", start); else pass_cnt++;
    total_cnt++; if (bus.s_ready !== 1'b0) $display("FAIL ov_s_ready got=%b exp=0", bus.s_ready); else pass_cnt++;
    total_cnt++; if (load_done !== 1'b0) $display("FAIL ov_load_done got=%b exp=0", load_done); else pass_cnt++;
    total_cnt++; if (byte_count !== 10'd512) $display("FAIL ov_byte_count got=%0d exp=512", byte_count); else pass_cnt++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk); pc = 64'(e.addr); #1;
      total_cnt++; if (inst[7:0] !== e.data) $display("FAIL ov_sb addr=%0d got=%02h exp=%02h", e.addr, inst[7:0], e.data); else pass_cnt++;
    end
  endtask

  task automatic test_random_gaps();
    logic acc;
    sb_t  e;
    do_reset();
    for (int i = 0; i < MB; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(8'($urandom), (i == MB - 1), acc);
    end
    total_cnt++; if (load_done !== 1'b1) $display("FAIL rg_load_done got=%b exp=1", load_done); else pass_cnt++;
    total_cnt++; if (error !== 1'b0) $display("FAIL rg_error got=%b exp=0", error); else pass_cnt++;
    total_cnt++; if (byte_count !== 10'd512) $display("FAIL rg_byte_count got=%0d exp=512", byte_count); else pass_cnt++;
    pc = 64'd508; #1;
    total_cnt++; if (inst !== {model_mem[511], model_mem[510], model_mem[509], model_mem[508]})
      $display("FAIL rg_pc508 got=%08h exp=%08h", inst, {model_mem[511], model_mem[510], model_mem[509], model_mem[508]}); else pass_cnt++;
    pc = 64'd510; #1;
    total_cnt++; if (inst !== {model_mem[1], model_mem[0], model_mem[511], model_mem[510]})
      $display("FAIL rg_pc510_wrap got=%08h exp=%08h", inst, {model_mem[1], model_mem[0], model_mem[511], model_mem[510]}); else pass_cnt++;
    pc = 64'd9; #1;
    total_cnt++; if (inst !== {model_mem[12], model_mem[11], model_mem[10], model_mem[9]})
      $display("FAIL rg_pc9_misaligned got=%08h exp=%08h", inst, {model_mem[12], model_mem[11], model_mem[10], model_mem[9]}); else pass_cnt++;
    pc = 64'hFFFF_0000_0000_0204; #1;
    total_cnt++; if (inst !== {model_mem[7], model_mem[6], model_mem[5], model_mem[4]})
      $display("FAIL rg_pc_high_bits got=%08h exp=%08h", inst, {model_mem[7], model_mem[6], model_mem[5], model_mem[4]}); else pass_cnt++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk); pc = 64'(e.addr); #1;
      total_cnt++; if (inst[7:0] !== e.data) $display("FAIL rg_sb addr=%0d got=%02h exp=%02h", e.addr, inst[7:0], e.data); else pass_cnt++;
    end
  endtask

  task automatic test_reset_midload();
    logic       acc;
    logic [7:0] fifth;
    int         falls_before;
    sb_t        e;
    logic [7:0] tail [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_reset();
    falls_before = start_falls;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) send_byte(~model_mem[4], 1'b0, acc);
      else        send_byte(8'($urandom), 1'b0, acc);
    end
    fifth = model_mem[4];
    // Assert reset between clock edges; control state must clear at once.
    #2 reset = 1'b0;
    #1;
    total_cnt++; if (byte_count !== 10'd0) $display("FAIL rm_async_count got=%0d exp=0", byte_count); else pass_cnt++;
    total_cnt++; if (bus.s_ready !== 1'b1) $display("FAIL rm_async_ready got=%b exp=1", bus.s_ready); else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    model_ptr = 0;
    sb.delete();
    for (int i = 0; i < 4; i++) send_byte(tail[i], (i == 3), acc);
    total_cnt++; if (load_done !== 1'b1) $display("FAIL rm_load_done got=%b exp=1", load_done); else pass_cnt++;
    total_cnt++; if (byte_count !== 10'd4) $display("FAIL rm_byte_count got=%0d exp=4", byte_count); else pass_cnt++;
    pc = 64'd0; #1;
    total_cnt++; if (inst !== 32'hDDCCBBAA) $display("FAIL rm_inst_pc0 got=%08h exp=DDCCBBAA", inst); else pass_cnt++;
    pc = 64'd4; #1;
    total_cnt++; if (inst[7:0] !== fifth) $display("FAIL rm_stale_mem4 got=%02h exp=%02h", inst[7:0], fifth); else pass_cnt++;
    total_cnt++; if (start_falls - falls_before !== 1) $display("FAIL rm_start_falls got=%0d exp=1", start_falls - falls_before); else pass_cnt++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk); pc = 64'(e.addr); #1;
      total_cnt++; if (inst[7:0] !== e.data) $display("FAIL rm_sb addr=%0d got=%02h exp=%02h", e.addr, inst[7:0], e.data); else pass_cnt++;
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    pc          = 64'd0;
    pass_cnt    = 0;
    total_cnt   = 0;
    model_ptr   = 0;
    #2 reset = 1'b0;

    test_reset();
    test_aligned_load();
    test_pad();
    test_overflow();
    test_random_gaps();
    test_reset_midload();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Upstream feeder for the single-cycle core `Top1`. It accepts a program as a byte stream over a valid/ready handshake and writes it little-endian into a 512-byte instruction memory. It holds the core's `start` high while loading, then releases it. It also serves the core's 32-bit instruction fetch from that memory, so the core never sees a partially loaded program.

## Interface
- `MEM_BYTES`, default 512: instruction memory size in bytes. Must be a power of two and a multiple of 4.
- `ADDR_W`, default 9: `log2(MEM_BYTES)`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low (0 = reset).
- `s_valid` input 1: a byte is offered on `s_data`.
- `s_data` input 8: program byte.
- `s_last` input 1: qualifies the final byte of the program; sampled only on a handshake.
- `s_ready` output 1: loader accepts a byte this cycle.
- `pc` input 64: core fetch address; only bits `[ADDR_W-1:0]` are used.
- `inst` output 32: `{mem[pc+3], mem[pc+2], mem[pc+1], mem[pc]}`.
- `start` output 1: core hold/initialise. High until the load completes.
- `load_done` output 1: program resident, core running.
- `byte_count` output `ADDR_W+1`: bytes written so far, including pad bytes.
- `error` output 1: overflow, sticky.

## Operation
- A handshake occurs when `s_valid && s_ready`. On a handshake, `mem[ptr] <= s_data` and `ptr <= ptr+1`.
- FSM states (enum `loader_state_t`):
  - IDLE: `s_ready=1`. The first handshake goes to LOAD. If `s_last` is set on that handshake, go to PAD or DONE as in LOAD.
  - LOAD: `s_ready=1`. On a handshake with `s_last`:
    - if `(ptr+1)%4 != 0`, go to PAD;
    - otherwise go to DONE.
  - PAD: `s_ready=0`. Writes `8'h00` at `ptr`, one byte per cycle, until `ptr%4==0`, then goes to DONE. Padding covers at most 3 cycles.
  - DONE: `s_ready=0`, `start=0`, `load_done=1`. The state is terminal until reset.
  - ERR: `s_ready=0`, `start=1`, `error=1`. The state is terminal until reset.
- Overflow: a handshake with `ptr==MEM_BYTES` writes nothing and goes to ERR. A last byte landing at `MEM_BYTES-1` is legal and goes to DONE.
- Fetch path:
  - Combinational, reading current memory contents in every state.
  - Byte addresses `pc+k` wrap modulo `MEM_BYTES`.
  - Misaligned `pc` is legal: bytes are taken as addressed.
- Memory contents are not cleared by reset. Only control state is reset.
- `byte_count` equals `ptr`.

## Timing
- Reset values:
  - state IDLE, `ptr=0`;
  - `s_ready=1`, `start=1`, `load_done=0`, `error=0`;
  - `byte_count=0`.
  - `inst` follows memory contents.
- Write latency: a byte accepted at edge N is visible on `inst` after edge N, i.e. during cycle N+1.
- `s_ready` is a Moore output of the state. It does not depend on `s_valid`.
- `start` falls, and `load_done` rises, on the edge that enters DONE:
  - the edge of the last byte when no padding is needed;
  - otherwise the edge that writes the final pad byte.
- `s_valid` high while `s_ready=0` is ignored; no data is consumed.
- Reset asserted mid-load: the FSM returns to IDLE immediately (asynchronously) and `ptr` returns to 0. The next load overwrites from address 0, and stale bytes above the new program length remain in memory.
- `error` and `load_done` are never both high.

## Structure
- Shared package `rv_pkg` holds:
  - `loader_state_t` (IDLE, LOAD, PAD, DONE, ERR);
  - `MEM_BYTES_DEF = 512`;
  - `INST_W = 32`.
- Sub-module `byte_ram`: `MEM_BYTES` x 8, one synchronous write port, four combinational read ports. The little-endian word assembly lives in `prog_loader`.
- The FSM, pointer and pad logic stay in `prog_loader`.

## Test plan
- Reset, then stream 8 bytes `83 00 01 00 03 82 01 00` with `s_last` on the 8th → no PAD; `start` falls on the 8th handshake edge. After that edge:
  - `pc=4` gives `inst=32'h00018203`;
  - `byte_count=8`.
- Stream 6 bytes with `s_last` on the 6th → PAD lasts 2 cycles with `s_ready=0`. Then `mem[6]=mem[7]=00`, `byte_count=8`, `load_done=1`.
- Stream 513 bytes with no `s_last` → the 513th handshake does not write. After that handshake:
  - `error=1`, `start=1`, `s_ready=0`;
  - `byte_count=512`;
  - `mem[511]` holds the 512th byte.
- Toggle `s_valid` randomly with a gap of 3 idle cycles; on `pc=508` after load → bytes are written in order. `inst={mem[511], mem[510], mem[509], mem[508]}`, and `pc=510` wraps to `{mem[1], mem[0], mem[511], mem[510]}`.
- Assert `reset` low after 5 of 20 bytes, release, then stream 4 bytes `AA BB CC DD` with `s_last` → `ptr` restarts at 0.
  - `pc=0` gives `inst=32'hDDCCBBAA`.
  - `mem[4]` still holds the 5th byte of the aborted load.
  - `start` falls once.
